bp_cce_dir_rd_seq: RTL and testbench

//  Sequences multi-cycle reads of one directory way-group from the CCE directory RAM and collapses them into
//  per-LCE hit/way/state vectors for the GAD stage. Also captures the requester's LRU entry.

---
 rtl/bp_cce_dir_rd_seq.sv | 218 +++++++++++++++++++++
 tb/tb_bp_cce_dir_rd_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_dir_rd_seq.sv
// Directory read sequencer: streams one way-group out of the CCE directory RAM and folds it into per-LCE sharer vectors.
// Optional build macro BP_CCE_DIR_MULTIHIT_CHECK_EN adds a sticky multihit_o flag and a simulation error on duplicate hits.

`ifndef BP_CCE_COH_BITS
`define BP_CCE_COH_BITS 3
`endif

module bp_cce_dir_rd_seq #(
  parameter int num_lce_p         = 8,
  parameter int lce_assoc_p       = 8,
  parameter int tag_width_p       = 28,
  parameter int num_way_groups_p  = 64,
  parameter int entries_per_row_p = 2,
  localparam int R      = num_lce_p * lce_assoc_p / entries_per_row_p,
  localparam int C      = `BP_CCE_COH_BITS,
  localparam int W      = tag_width_p + C,
  localparam int LG_LCE = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int LG_A   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int LG_WG  = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
  localparam int LG_R   = (R > 1) ? $clog2(R) : 1,
  localparam int ADDR_W = $clog2(num_way_groups_p * R)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [LG_WG-1:0]               way_group_i,
  input  logic [tag_width_p-1:0]         tag_i,
  input  logic [LG_LCE-1:0]              req_lce_i,
  input  logic [LG_A-1:0]                lru_way_i,
  output logic                           dir_rd_v_o,
  output logic [ADDR_W-1:0]              dir_rd_addr_o,
  input  logic [entries_per_row_p*W-1:0] dir_rd_data_i,
  output logic                           sharers_v_o,
  output logic [num_lce_p-1:0]           sharers_hits_o,
  output logic [num_lce_p*LG_A-1:0]      sharers_ways_o,
  output logic [num_lce_p*C-1:0]         sharers_coh_states_o,
  output logic                           lru_cached_excl_o,
  output logic                           lru_dirty_o,
  output logic [tag_width_p-1:0]         lru_tag_o
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
 ,output logic                           multihit_o
`endif
);

  localparam int E             = entries_per_row_p;
  localparam int COH_SHARED_BIT = 0;
  localparam int COH_DIRTY_BIT  = 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                   r_state;
  logic [LG_R-1:0]          r_row;
  logic                     r_rdV;
  logic [ADDR_W-1:0]        r_rdAddr;
  logic                     r_dataV;
  logic [LG_R-1:0]          r_dataRow;
  logic [tag_width_p-1:0]   r_tag;
  logic [LG_LCE-1:0]        r_reqLce;
  logic [LG_A-1:0]          r_lruWay;
  logic                     r_sharersV;
  logic [num_lce_p-1:0]     r_hits;
  logic [num_lce_p*LG_A-1:0] r_ways;
  logic [num_lce_p*C-1:0]   r_coh;
  logic                     r_lruExcl;
  logic                     r_lruDirty;
  logic [tag_width_p-1:0]   r_lruTag;
  logic                     r_multi;

  logic [num_lce_p-1:0]      w_hitsN;
  logic [num_lce_p*LG_A-1:0] w_waysN;
  logic [num_lce_p*C-1:0]    w_cohN;
  logic                      w_lruLoad;
  logic [W-1:0]              w_lruEntry;
  logic                      w_multi;
  logic                      w_accept;
  logic [ADDR_W-1:0]         w_base;

  assign ready_o  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = v_i && ready_o;
  assign w_base   = ADDR_W'(way_group_i) * ADDR_W'(R);

  // Entries are visited in ascending way order, so the first hit seen for an LCE is its lowest way.
  always_comb begin : absorb
    int                     g;
    int                     lce;
    int                     way;
    logic [W-1:0]           entry;
    logic [tag_width_p-1:0] eTag;
    logic [C-1:0]           eCoh;
    g          = 0;
    lce        = 0;
    way        = 0;
    entry      = '0;
    eTag       = '0;
    eCoh       = '0;
    w_hitsN    = r_hits;
    w_waysN    = r_ways;
    w_cohN     = r_coh;
    w_lruLoad  = 1'b0;
    w_lruEntry = '0;
    w_multi    = 1'b0;
    for (int j = 0; j < E; j++) begin
      g     = int'(r_dataRow) * E + j;
      lce   = g / lce_assoc_p;
      way   = g % lce_assoc_p;
      entry = dir_rd_data_i[j*W +: W];
      eTag  = entry[W-1 -: tag_width_p];
      eCoh  = entry[C-1:0];
      if ((eTag == r_tag) && (eCoh != '0)) begin
        if (w_hitsN[lce]) begin
          w_multi = 1'b1;
        end else begin
          w_hitsN[lce]             = 1'b1;
          w_waysN[lce*LG_A +: LG_A] = LG_A'(way);
          w_cohN[lce*C +: C]       = eCoh;
        end
      end
      if ((lce == int'(r_reqLce)) && (way == int'(r_lruWay))) begin
        w_lruLoad  = 1'b1;
        w_lruEntry = entry;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_rdV      <= 1'b0;
      r_rdAddr   <= '0;
      r_dataV    <= 1'b0;
      r_dataRow  <= '0;
      r_tag      <= '0;
      r_reqLce   <= '0;
      r_lruWay   <= '0;
      r_sharersV <= 1'b0;
      r_hits     <= '0;
      r_ways     <= '0;
      r_coh      <= '0;
      r_lruExcl  <= 1'b0;
      r_lruDirty <= 1'b0;
      r_lruTag   <= '0;
      r_multi    <= 1'b0;
    end else begin
      r_dataV   <= r_rdV;
      r_dataRow <= r_row;
      if (r_dataV) begin
        r_hits <= w_hitsN;
        r_ways <= w_waysN;
        r_coh  <= w_cohN;
        if (w_multi) r_multi <= 1'b1;
        if (w_lruLoad) begin
          r_lruTag   <= w_lruEntry[W-1 -: tag_width_p];
          r_lruExcl  <= (w_lruEntry[C-1:0] != '0) && !w_lruEntry[COH_SHARED_BIT];
          r_lruDirty <= w_lruEntry[COH_DIRTY_BIT];
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state    <= S_READ;
            r_tag      <= tag_i;
            r_reqLce   <= req_lce_i;
            r_lruWay   <= lru_way_i;
            r_rdV      <= 1'b1;
            r_rdAddr   <= w_base;
            r_row      <= '0;
            r_sharersV <= 1'b0;
            r_hits     <= '0;
            r_ways     <= '0;
            r_coh      <= '0;
            r_lruTag   <= '0;
            r_lruExcl  <= 1'b0;
            r_lruDirty <= 1'b0;
          end
        end
        S_READ: begin
          if (r_row == LG_R'(R - 1)) begin
            r_rdV   <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_row    <= r_row + LG_R'(1);
            r_rdAddr <= r_rdAddr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          r_state    <= S_DONE;
          r_sharersV <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dir_rd_v_o           = r_rdV;
  assign dir_rd_addr_o        = r_rdAddr;
  assign sharers_v_o          = r_sharersV;
  assign sharers_hits_o       = r_hits;
  assign sharers_ways_o       = r_ways;
  assign sharers_coh_states_o = r_coh;
  assign lru_cached_excl_o    = r_lruExcl;
  assign lru_dirty_o          = r_lruDirty;
  assign lru_tag_o            = r_lruTag;

`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  assign multihit_o = r_multi;
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && r_dataV && w_multi) $error("bp_cce_dir_rd_seq: multiple hits in one LCE");
  end
`endif
`else
  logic w_unusedMulti;
  assign w_unusedMulti = r_multi;
`endif

endmodule

// File: tb/tb_bp_cce_dir_rd_seq.sv
// Directed table-driven bench for bp_cce_dir_rd_seq with a behavioural directory RAM (default parameters, R=32).
// Build with BP_CCE_DIR_MULTIHIT_CHECK_EN defined to also exercise multihit_o.

module tb_bp_cce_dir_rd_seq;

  localparam int W  = 31;
  localparam int NR = 2048;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [5:0]  way_group_i;
  logic [27:0] tag_i;
  logic [2:0]  req_lce_i;
  logic [2:0]  lru_way_i;
  logic        dir_rd_v_o;
  logic [10:0] dir_rd_addr_o;
  logic [61:0] dir_rd_data_i;
  logic        sharers_v_o;
  logic [7:0]  sharers_hits_o;
  logic [23:0] sharers_ways_o;
  logic [23:0] sharers_coh_states_o;
  logic        lru_cached_excl_o;
  logic        lru_dirty_o;
  logic [27:0] lru_tag_o;
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  logic        multihit_o;
`endif

  bp_cce_dir_rd_seq dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .way_group_i(way_group_i), .tag_i(tag_i), .req_lce_i(req_lce_i), .lru_way_i(lru_way_i),
    .dir_rd_v_o(dir_rd_v_o), .dir_rd_addr_o(dir_rd_addr_o), .dir_rd_data_i(dir_rd_data_i),
    .sharers_v_o(sharers_v_o), .sharers_hits_o(sharers_hits_o), .sharers_ways_o(sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o), .lru_cached_excl_o(lru_cached_excl_o),
    .lru_dirty_o(lru_dirty_o), .lru_tag_o(lru_tag_o)
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
   ,.multihit_o(multihit_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [61:0] mem [NR];

  always @(posedge clk_i) begin
    if (dir_rd_v_o) dir_rd_data_i <= mem[dir_rd_addr_o];
  end

  typedef struct {
    string       name;
    int          wg;
    logic [27:0] tag;
    int          reqLce;
    int          lruWay;
    logic [7:0]  expHits;
    logic [23:0] expWays;
    logic [23:0] expCoh;
    logic        expExcl;
    logic        expDirty;
    logic [27:0] expLruTag;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   fails  = 0;

  function automatic vec_t mk(string n, int wg, logic [27:0] tag, int rl, int lw, logic [7:0] h,
                              logic [23:0] wy, logic [23:0] ch, logic ex, logic dt, logic [27:0] lt);
    vec_t v;
    v.name = n; v.wg = wg; v.tag = tag; v.reqLce = rl; v.lruWay = lw;
    v.expHits = h; v.expWays = wy; v.expCoh = ch; v.expExcl = ex; v.expDirty = dt; v.expLruTag = lt;
    return v;
  endfunction

  task automatic writeEntry(input int wg, input int lce, input int way, input logic [27:0] tag, input logic [2:0] coh);
    int          g;
    logic [61:0] row;
    g   = lce * 8 + way;
    row = mem[wg*32 + g/2];
    row[(g%2)*W +: W] = {tag, coh};
    mem[wg*32 + g/2] = row;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one lookup and follows it to sharers_v_o, checking the strobe/address walk along the way.
  task automatic applyStimulus(input vec_t v, input int noiseCyc, output int latency, output int seqErr, output logic vDropOk);
    int n;
    int cyc;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    way_group_i = 6'(v.wg);
    tag_i       = v.tag;
    req_lce_i   = 3'(v.reqLce);
    lru_way_i   = 3'(v.lruWay);
    v_i         = 1'b1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    cyc = 0; latency = -1; seqErr = 0; vDropOk = 1'b0;
    while (cyc < 60) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) vDropOk = !sharers_v_o;
      if (cyc <= 32) begin
        if (!dir_rd_v_o || (dir_rd_addr_o != 11'(v.wg*32 + cyc - 1)) || ready_o) seqErr++;
      end else if (!sharers_v_o && (dir_rd_v_o || ready_o)) begin
        seqErr++;
      end
      if (sharers_v_o && cyc > 1) begin
        latency = cyc;
        break;
      end
      if (noiseCyc > 0 && cyc == noiseCyc) begin
        v_i = 1'b1; way_group_i = 6'd63; tag_i = 28'h0ABC;
      end else begin
        v_i = 1'b0;
      end
    end
    v_i = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int noiseCyc);
    int   lat;
    int   se;
    logic vd;
    applyStimulus(v, noiseCyc, lat, se, vd);
    checkOutput({v.name, ".latency"}, 64'(lat), 64'd34);
    checkOutput({v.name, ".strobeSeq"}, 64'(se), 64'd0);
    checkOutput({v.name, ".vDrop"}, 64'(vd), 64'd1);
    checkOutput({v.name, ".hits"}, 64'(sharers_hits_o), 64'(v.expHits));
    checkOutput({v.name, ".ways"}, 64'(sharers_ways_o), 64'(v.expWays));
    checkOutput({v.name, ".coh"}, 64'(sharers_coh_states_o), 64'(v.expCoh));
    checkOutput({v.name, ".lruTag"}, 64'(lru_tag_o), 64'(v.expLruTag));
    checkOutput({v.name, ".lruExcl"}, 64'(lru_cached_excl_o), 64'(v.expExcl));
    checkOutput({v.name, ".lruDirty"}, 64'(lru_dirty_o), 64'(v.expDirty));
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int strobes;
    for (int i = 0; i < NR; i++) mem[i] = '0;
    dir_rd_data_i = '0;
    // coh encoding: I=0 S=1 E=2 F=3 M=6
    writeEntry(5, 2, 3, 28'h123, 3'd6);
    writeEntry(5, 6, 1, 28'h124, 3'd1);
    writeEntry(9, 0, 1, 28'h456, 3'd1);
    writeEntry(9, 7, 6, 28'h456, 3'd2);
    writeEntry(9, 4, 0, 28'h456, 3'd0);
    writeEntry(12, 1, 5, 28'h077, 3'd6);
    writeEntry(12, 3, 4, 28'h099, 3'd1);
    writeEntry(20, 3, 2, 28'hABC, 3'd2);
    writeEntry(20, 3, 5, 28'hABC, 3'd1);
    writeEntry(20, 5, 0, 28'hABC, 3'd1);
    writeEntry(20, 5, 1, 28'hABC, 3'd6);
    writeEntry(63, 7, 7, 28'hFFFFFFF, 3'd3);
    writeEntry(0, 0, 0, 28'h0, 3'd1);

    vecs[0] = mk("wg5",     5,  28'h123,     2, 3, 8'h04, 24'h0000C0, 24'h000180, 1'b1, 1'b1, 28'h123);
    vecs[1] = mk("wg9",     9,  28'h456,     4, 0, 8'h81, 24'hC00001, 24'h400001, 1'b0, 1'b0, 28'h456);
    vecs[2] = mk("wg12",    12, 28'h099,     1, 5, 8'h08, 24'h000800, 24'h000200, 1'b1, 1'b1, 28'h077);
    vecs[3] = mk("wg20",    20, 28'hABC,     0, 0, 8'h28, 24'h000400, 24'h008400, 1'b0, 1'b0, 28'h0);
    vecs[4] = mk("wg63",    63, 28'hFFFFFFF, 7, 7, 8'h80, 24'hE00000, 24'h600000, 1'b0, 1'b0, 28'hFFFFFFF);
    vecs[5] = mk("wg0",     0,  28'h0,       0, 0, 8'h01, 24'h000000, 24'h000001, 1'b0, 1'b0, 28'h0);
    vecs[6] = mk("wg5s",    5,  28'h124,     6, 1, 8'h40, 24'h040000, 24'h040000, 1'b0, 1'b0, 28'h124);
    vecs[7] = mk("wg9miss", 9,  28'h999,     7, 6, 8'h00, 24'h000000, 24'h000000, 1'b1, 1'b0, 28'h456);

    reset_i = 1'b1; v_i = 1'b0; way_group_i = '0; tag_i = '0; req_lce_i = '0; lru_way_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst.ready", 64'(ready_o), 64'd1);
    checkOutput("rst.rdV", 64'(dir_rd_v_o), 64'd0);
    checkOutput("rst.sharersV", 64'(sharers_v_o), 64'd0);
    checkOutput("rst.vectors", 64'({sharers_hits_o, sharers_ways_o, sharers_coh_states_o}), 64'd0);
    checkOutput("rst.lru", 64'({lru_tag_o, lru_cached_excl_o, lru_dirty_o}), 64'd0);
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("idle.ready", 64'(ready_o), 64'd1);
    checkOutput("idle.rdV", 64'(dir_rd_v_o), 64'd0);
    checkOutput("idle.sharersV", 64'(sharers_v_o), 64'd0);

    $display("[TB] running %0d table vectors back to back", 8);
    for (int i = 0; i < 8; i++) runVector(vecs[i], 0);

    repeat (4) @(negedge clk_i);
    checkOutput("done.sharersV", 64'(sharers_v_o), 64'd1);
    checkOutput("done.ready", 64'(ready_o), 64'd1);
    checkOutput("done.hitsHeld", 64'(sharers_hits_o), 64'(vecs[7].expHits));
    checkOutput("done.lruHeld", 64'(lru_tag_o), 64'(vecs[7].expLruTag));
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
    checkOutput("multihit.sticky", 64'(multihit_o), 64'd1);
`endif

    $display("[TB] request pulsed during READ must be ignored");
    runVector(vecs[0], 10);
    repeat (2) @(negedge clk_i);
    checkOutput("noise.stillDone", 64'(sharers_v_o), 64'd1);

    $display("[TB] reset asserted while row 10 is strobed");
    way_group_i = 6'd9; tag_i = 28'h456; req_lce_i = 3'd4; lru_way_i = 3'd0;
    v_i = 1'b1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    repeat (11) @(negedge clk_i);
    checkOutput("midRd.addrRow10", 64'(dir_rd_addr_o), 64'(9*32 + 10));
    reset_i = 1'b1;
    #1;
    checkOutput("midRd.rdV", 64'(dir_rd_v_o), 64'd0);
    checkOutput("midRd.ready", 64'(ready_o), 64'd1);
    checkOutput("midRd.hits", 64'(sharers_hits_o), 64'd0);
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
    checkOutput("multihit.cleared", 64'(multihit_o), 64'd0);
`endif
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (dir_rd_v_o || sharers_v_o) strobes++;
    end
    checkOutput("midRd.noStrobes", 64'(strobes), 64'd0);
    runVector(vecs[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
